// File: rtl/io_mem_pkg.sv
// io_mem_pkg: shared types and helpers for the io_mem_slave memory responder.
//   io_rsp_t    - one response pipeline entry {valid, err, rdata}; rdata is
//                 sized for the widest supported bus and truncated at the top.
//   bytes_of    - byte lanes per word          (BYTES)
//   words_of    - words in the memory window   (WORDS)
//   idx_w_of    - word index width             (IDX_W), never below 1
//   word_index  - byte address -> word index inside the window
package io_mem_pkg;

  localparam int DATA_W_MAX = 64;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_W_MAX-1:0] rdata;
  } io_rsp_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int words_of(input int depth_bytes, input int data_w);
    return depth_bytes / bytes_of(data_w);
  endfunction

  function automatic int idx_w_of(input int depth_bytes, input int data_w);
    return (words_of(depth_bytes, data_w) > 1) ? $clog2(words_of(depth_bytes, data_w)) : 1;
  endfunction

  // Drops the in-word byte offset, then masks to the window so that upper
  // address bits alias onto the same words.
  function automatic int word_index(input logic [63:0] addr, input int depth_bytes,
                                    input int data_w);
    logic [63:0] w;
    w = addr >> $clog2(bytes_of(data_w));
    w = w & 64'(words_of(depth_bytes, data_w) - 1);
    return int'(w[31:0]);
  endfunction

endpackage

// File: rtl/io_mem_slave_rsp_pipe.sv
// io_mem_rsp_pipe: fixed-length delay line for io_rsp_t entries.
//   clk    - clock
//   rst    - asynchronous active-high clear; drops everything in flight
//   rsp_i  - entry captured at every rising edge
//   rsp_o  - entry captured RSP_LATENCY edges earlier
module io_mem_rsp_pipe
  import io_mem_pkg::*;
#(
  parameter int RSP_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  io_rsp_t rsp_i,
  output io_rsp_t rsp_o
);

  io_rsp_t stage_q [RSP_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < RSP_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign rsp_o = stage_q[RSP_LATENCY-1];

endmodule

// File: rtl/io_mem_slave.sv
// io_mem_slave: byte-enabled memory responder for the io_req bus.
//   clk, rst        - clock, asynchronous active-high reset
//   io_req_i        - request valid (held until io_req_ack_o)
//   io_wr_i         - 1 = write, 0 = read
//   io_wen_i        - write byte-lane enables (ignored on reads)
//   io_addr_i       - byte address; top nibble must equal BASE_NIBBLE
//   io_wdata_i      - write data
//   stall_req_i     - back-pressure, blocks acceptance
//   io_req_ack_o    - request accepted this cycle (combinational)
//   io_data_ack_o   - one-cycle response strobe, RSP_LATENCY after acceptance
//   io_rdata_o      - read data, zero unless io_data_ack_o
//   io_err_o        - error flag, zero unless io_data_ack_o
//   outstanding_o   - accepted-but-unanswered request count
module io_mem_slave
  import io_mem_pkg::*;
#(
  parameter int         ADDR_W          = 32,
  parameter int         DATA_W          = 32,
  parameter int         DEPTH_BYTES     = 256,
  parameter int         RSP_LATENCY     = 1,
  parameter int         MAX_OUTSTANDING = 1,
  parameter logic [3:0] BASE_NIBBLE     = 4'hF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 io_req_i,
  input  logic                                 io_wr_i,
  input  logic [DATA_W/8-1:0]                  io_wen_i,
  input  logic [ADDR_W-1:0]                    io_addr_i,
  input  logic [DATA_W-1:0]                    io_wdata_i,
  input  logic                                 stall_req_i,
  output logic                                 io_req_ack_o,
  output logic [DATA_W-1:0]                    io_rdata_o,
  output logic                                 io_data_ack_o,
  output logic                                 io_err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int WORDS = words_of(DEPTH_BYTES, DATA_W);
  localparam int IDX_W = idx_w_of(DEPTH_BYTES, DATA_W);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("io_mem_slave: DATA_W must be 32 or 64");
  end
  if (DEPTH_BYTES <= 0 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0 ||
      (DEPTH_BYTES % (DATA_W / 8)) != 0) begin : g_bad_depth
    $error("io_mem_slave: DEPTH_BYTES must be a power of two and a multiple of DATA_W/8");
  end
  if (RSP_LATENCY < 1 || RSP_LATENCY > 8) begin : g_bad_latency
    $error("io_mem_slave: RSP_LATENCY must be in 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RSP_LATENCY) begin : g_bad_outstanding
    $error("io_mem_slave: MAX_OUTSTANDING must be in 1..RSP_LATENCY");
  end
  if (ADDR_W > 64 || (1 << (ADDR_W - 4)) < DEPTH_BYTES) begin : g_bad_addr_w
    $error("io_mem_slave: ADDR_W too small for the window or wider than 64");
  end

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [IDX_W-1:0]  widx;
  logic              req_err;
  logic              accept;
  logic              rsp_ack;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  io_rsp_t           rsp_in, rsp_out;
  logic              unused_rsp_bits;

  assign widx = IDX_W'(word_index(64'(io_addr_i), DEPTH_BYTES, DATA_W));

  assign io_req_ack_o = io_req_i & ~stall_req_i & ~rst &
                        (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign accept = io_req_i & io_req_ack_o;

  assign req_err = (io_addr_i[ADDR_W-1 -: 4] != BASE_NIBBLE) |
                   (io_wr_i & (io_wen_i == '0));

  // Memory is deliberately not reset so writes survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (accept && io_wr_i && !req_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (io_wen_i[b]) mem_q[widx][b*8 +: 8] <= io_wdata_i[b*8 +: 8];
      end
    end
  end

  // The read word is taken from the pre-edge array contents, so a read sees
  // every write accepted on an earlier edge.
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    rsp_in.err   = accept & req_err;
    if (accept && !io_wr_i && !req_err) rsp_in.rdata = DATA_W_MAX'(mem_q[widx]);
  end

  io_mem_rsp_pipe #(
    .RSP_LATENCY(RSP_LATENCY)
  ) u_rsp_pipe (
    .clk  (clk),
    .rst  (rst),
    .rsp_i(rsp_in),
    .rsp_o(rsp_out)
  );

  assign rsp_ack         = rsp_out.valid;
  assign io_data_ack_o   = rsp_ack;
  assign io_err_o        = rsp_ack & rsp_out.err;
  assign io_rdata_o      = rsp_ack ? rsp_out.rdata[DATA_W-1:0] : '0;
  assign unused_rsp_bits = ^rsp_out.rdata;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, rsp_ack})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding_q <= '0;
    else     outstanding_q <= outstanding_d;
  end

  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_io_mem_slave.sv
// Bench for io_mem_slave: instance 0 uses the defaults (latency 1, single
// outstanding), instance 1 uses latency 3 with two outstanding requests.
module tb_io_mem_slave;

  typedef struct {
    logic        wr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req     [2];
  logic        wr      [2];
  logic        stall   [2];
  logic [3:0]  wen     [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic        req_ack [2];
  logic        dack    [2];
  logic        err     [2];
  logic [31:0] rdata   [2];
  logic [0:0]  outs0;
  logic [1:0]  outs1;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  vec_t tbl [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  io_mem_slave u_a (
    .clk(clk), .rst(rst),
    .io_req_i(req[0]), .io_wr_i(wr[0]), .io_wen_i(wen[0]), .io_addr_i(addr[0]),
    .io_wdata_i(wdata[0]), .stall_req_i(stall[0]),
    .io_req_ack_o(req_ack[0]), .io_rdata_o(rdata[0]), .io_data_ack_o(dack[0]),
    .io_err_o(err[0]), .outstanding_o(outs0)
  );

  io_mem_slave #(.RSP_LATENCY(3), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .rst(rst),
    .io_req_i(req[1]), .io_wr_i(wr[1]), .io_wen_i(wen[1]), .io_addr_i(addr[1]),
    .io_wdata_i(wdata[1]), .stall_req_i(stall[1]),
    .io_req_ack_o(req_ack[1]), .io_rdata_o(rdata[1]), .io_data_ack_o(dack[1]),
    .io_err_o(err[1]), .outstanding_o(outs1)
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int outs_of(input int k);
    return (k == 0) ? int'(outs0) : int'(outs1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push_exp(input int k, input logic e, input logic [31:0] d);
    exp_t x;
    x.err = e;
    x.rd  = d;
    x.due = cyc + lat_of(k);
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Scoreboard: every response is matched in order against the queue.
  always @(negedge clk) begin
    exp_t x;
    for (int k = 0; k < 2; k++) begin
      if (dack[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          chk($sformatf("spurious_ack%0d", k), dack[k], 1'b0);
        end else begin
          if (k == 0) x = q0.pop_front();
          else        x = q1.pop_front();
          chk($sformatf("rsp_err%0d", k), err[k], x.err);
          chk($sformatf("rsp_rdata%0d", k), rdata[k], x.rd);
          chk($sformatf("rsp_latency%0d", k), cyc, x.due);
        end
      end else begin
        chk($sformatf("idle_zero%0d", k), {err[k], rdata[k]}, 64'd0);
      end
      chk($sformatf("outs_bound%0d", k), outs_of(k) <= max_of(k), 1'b1);
    end
  end

  // Presents one request, waits (bounded) for acceptance, records the
  // expected response and drops io_req right after the accepting edge.
  task automatic issue(input int k, input logic w, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
    int n = 0;
    req[k] = 1'b1; wr[k] = w; wen[k] = be; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    while (!req_ack[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accepted%0d_%h", k, a), req_ack[k], 1'b1);
    if (req_ack[k]) push_exp(k, e_err, e_rd);
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size() + q1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b1; wr[k] = 1'b0; stall[k] = 1'b0; wen[k] = 4'h0;
      addr[k] = 32'hF000_0000; wdata[k] = 32'h0;
    end

    tbl[0]  = '{1'b1, 4'hF, 32'hF000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 4'h0, 32'hF000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 4'hF, 32'hF000_0020, 32'h1122_3344, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 4'h1, 32'hF000_0020, 32'h0000_00AA, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 4'hC, 32'hF000_0020, 32'h5566_0000, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 4'h0, 32'hF000_0020, 32'h0,         1'b0, 32'h5566_33AA};
    tbl[6]  = '{1'b0, 4'h0, 32'hE000_0000, 32'h0,         1'b1, 32'h0};
    tbl[7]  = '{1'b1, 4'hF, 32'hF000_0004, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 4'h0, 32'hF000_0004, 32'h1234_5678, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 4'h0, 32'hF000_0004, 32'h0,         1'b0, 32'hCAFE_F00D};
    tbl[10] = '{1'b0, 4'h0, 32'hF000_0113, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[11] = '{1'b1, 4'hF, 32'hF000_00FC, 32'h0102_0304, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 4'hA, 32'hF000_00FC, 32'hAABB_CCDD, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 4'h0, 32'hF000_00FC, 32'h0,         1'b0, 32'hAA02_CC04};
    tbl[14] = '{1'b1, 4'hF, 32'h7000_0010, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 4'h0, 32'hF000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

    // Reset state, with io_req held high to exercise the reset gating.
    @(negedge clk);
    chk("rst_req_ack_a", req_ack[0], 1'b0);
    chk("rst_req_ack_b", req_ack[1], 1'b0);
    chk("rst_outs_a", outs0, 1'b0);
    chk("rst_outs_b", outs1, 2'd0);
    @(posedge clk); #1;
    req[0] = 1'b0; req[1] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table on the default instance.
    for (int i = 0; i < 16; i++) begin
      issue(0, tbl[i].wr, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rd);
    end
    drain();

    issue(1, 1'b1, 4'hF, 32'hF000_0000, 32'h1010_1010, 1'b0, 32'h0);
    issue(1, 1'b1, 4'hF, 32'hF000_0004, 32'h2020_2020, 1'b0, 32'h0);
    issue(1, 1'b1, 4'hF, 32'hF000_0008, 32'h3030_3030, 1'b0, 32'h0);
    drain();

    // Back-to-back reads against the two-deep instance.
    req[1] = 1'b1; wr[1] = 1'b0; wen[1] = 4'h0; addr[1] = 32'hF000_0000;
    @(negedge clk);
    chk("b2b_ack_c0", req_ack[1], 1'b1);
    chk("b2b_outs_c0", outs1, 2'd0);
    push_exp(1, 1'b0, 32'h1010_1010);
    @(posedge clk); #1;
    chk("b2b_outs_e0", outs1, 2'd1);
    addr[1] = 32'hF000_0004;
    @(negedge clk);
    chk("b2b_ack_c1", req_ack[1], 1'b1);
    push_exp(1, 1'b0, 32'h2020_2020);
    @(posedge clk); #1;
    chk("b2b_outs_e1", outs1, 2'd2);
    addr[1] = 32'hF000_0008;
    @(negedge clk);
    chk("b2b_ack_c2", req_ack[1], 1'b0);
    @(posedge clk); #1;
    chk("b2b_outs_e2", outs1, 2'd2);
    @(negedge clk);
    chk("b2b_ack_c3", req_ack[1], 1'b0);
    @(posedge clk); #1;
    chk("b2b_outs_e3", outs1, 2'd1);
    @(negedge clk);
    chk("b2b_ack_c4", req_ack[1], 1'b1);
    push_exp(1, 1'b0, 32'h3030_3030);
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("b2b_outs_e4", outs1, 2'd1);
    drain();

    // Back-pressure: five stalled cycles, then acceptance on release.
    stall[1] = 1'b1;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'hF000_0004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ack", req_ack[1], 1'b0);
      chk("stall_outs", outs1, 2'd0);
    end
    @(posedge clk); #1;
    stall[1] = 1'b0;
    @(negedge clk);
    chk("unstall_ack", req_ack[1], 1'b1);
    push_exp(1, 1'b0, 32'h2020_2020);
    @(posedge clk); #1;
    req[1] = 1'b0;
    drain();

    // Reset with two requests in flight: their responses must never appear.
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'hF000_0000;
    @(negedge clk);
    chk("pre_rst_ack0", req_ack[1], 1'b1);
    @(posedge clk); #1;
    addr[1] = 32'hF000_0004;
    @(negedge clk);
    chk("pre_rst_ack1", req_ack[1], 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_outs", outs1, 2'd2);
    rst = 1'b1;
    #1;
    chk("rst_outs_now", outs1, 2'd0);
    chk("rst_req_ack_now", req_ack[1], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    req[1] = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    issue(1, 1'b0, 4'h0, 32'hF000_0008, 32'h0, 1'b0, 32'h3030_3030);
    issue(1, 1'b0, 4'h0, 32'hF000_0000, 32'h0, 1'b0, 32'h1010_1010);
    issue(0, 1'b0, 4'h0, 32'hF000_0020, 32'h0, 1'b0, 32'h5566_33AA);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
